// File: rtl/branch_predictor_pkg.sv
// Shared widths and 2-bit counter encodings for the fetch-side branch predictor.
package branch_predictor_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } cnt_e;

  // Tag covers everything above the index and the ignored byte-offset bits.
  function automatic int tag_bits(input int idx_bits);
    return WORD - idx_bits - 2;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating up/down counter, pure next-state logic.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
      else                 cnt_o = cnt_i;
    end else begin
      if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
      else                  cnt_o = cnt_i;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: same-cycle fetch prediction, update on
// resolve, combinational mispredict/redirect, and saturating statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic            clock,
  input  logic            resetN,
  input  logic [WORD-1:0] fetchPC,
  output logic            predTaken,
  output logic [WORD-1:0] predTarget,
  input  logic            resolveValid,
  input  logic [WORD-1:0] resolvePC,
  input  logic            resolveTaken,
  input  logic [WORD-1:0] resolveTarget,
  input  logic [WORD-1:0] resolveNextPC,
  input  logic            resolvePredTaken,
  input  logic [WORD-1:0] resolvePredTarget,
  output logic            mispredict,
  output logic [WORD-1:0] redirectPC,
  output logic [WORD-1:0] branchCount,
  output logic [WORD-1:0] mispredictCount
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = tag_bits(IDX_BITS);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [1:0]        cnt_q    [ENTRIES];
  logic [WORD-1:0]   target_q [ENTRIES];

  logic [IDX_BITS-1:0] fidx_s, ridx_s;
  logic [TAG_W-1:0]    ftag_s, rtag_s;
  logic                fhit_s, rhit_s;
  logic [1:0]          cnt_next_s;
  logic                wr_en_d, valid_d;
  logic [TAG_W-1:0]    tag_d;
  logic [1:0]          cnt_d;
  logic [WORD-1:0]     target_d;
  logic [WORD-1:0]     branch_cnt_q, branch_cnt_d;
  logic [WORD-1:0]     mispred_cnt_q, mispred_cnt_d;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{fetchPC[1:0], resolvePC[1:0]};

  assign fidx_s = fetchPC[IDX_BITS+1:2];
  assign ftag_s = fetchPC[WORD-1:IDX_BITS+2];
  assign ridx_s = resolvePC[IDX_BITS+1:2];
  assign rtag_s = resolvePC[WORD-1:IDX_BITS+2];

  assign fhit_s = valid_q[fidx_s] && (tag_q[fidx_s] == ftag_s);
  assign rhit_s = valid_q[ridx_s] && (tag_q[ridx_s] == rtag_s);

  // No bypass: fetch sees the table as it stood before this cycle's update.
  assign predTaken  = fhit_s && cnt_q[fidx_s][1];
  assign predTarget = predTaken ? target_q[fidx_s] : fetchPC + 32'd4;

  assign mispredict = resolveValid &&
                      ((resolveTaken != resolvePredTaken) ||
                       (resolveTaken && (resolveTarget != resolvePredTarget)));
  assign redirectPC = !resolveValid ? 32'd0 :
                      (resolveTaken ? resolveTarget : resolveNextPC);

  sat_counter2 u_cnt (
    .cnt_i (cnt_q[ridx_s]),
    .inc_i (resolveTaken),
    .cnt_o (cnt_next_s)
  );

  always_comb begin
    wr_en_d  = 1'b0;
    valid_d  = valid_q[ridx_s];
    tag_d    = tag_q[ridx_s];
    cnt_d    = cnt_q[ridx_s];
    target_d = target_q[ridx_s];
    if (resolveValid) begin
      if (rhit_s) begin
        wr_en_d  = 1'b1;
        cnt_d    = cnt_next_s;
        target_d = resolveTaken ? resolveTarget : target_q[ridx_s];
      end else if (resolveTaken) begin
        // Allocation evicts whatever aliasing branch held this slot.
        wr_en_d  = 1'b1;
        valid_d  = 1'b1;
        tag_d    = rtag_s;
        cnt_d    = CNT_INIT;
        target_d = resolveTarget;
      end else begin
        wr_en_d  = 1'b0;
      end
    end else begin
      wr_en_d = 1'b0;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolveValid && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_d = branch_cnt_q + 32'd1;
    else                                                 branch_cnt_d = branch_cnt_q;
    if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_d = mispred_cnt_q + 32'd1;
    else                                                mispred_cnt_d = mispred_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= 2'd0;
        target_q[i] <= 32'd0;
      end
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (wr_en_d) begin
        valid_q[ridx_s]  <= valid_d;
        tag_q[ridx_s]    <= tag_d;
        cnt_q[ridx_s]    <= cnt_d;
        target_q[ridx_s] <= target_d;
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branchCount     = branch_cnt_q;
  assign mispredictCount = mispred_cnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart of the execute-stage branch decision logic.
- Fetch presents a PC each cycle and gets a taken/target prediction from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- The execute stage returns each resolved conditional branch (actual taken, actual target, the prediction it carried). The block updates its tables and flags mispredicts with the correct redirect PC.
- Also keeps branch and mispredict statistics counters.

Parameters:
- IDX_BITS, 4: log2 of BTB entries (16 entries).
- CNT_INIT, 2'b10: counter value written on allocation (weakly taken).

Ports:
- clock  in  1  rising-edge clock.
- resetN  in  1  synchronous active-low reset.
- fetchPC  in  32  PC being fetched.
- predTaken  out  1  prediction for fetchPC.
- predTarget  out  32  predicted next PC for fetchPC.
- resolveValid  in  1  a conditional branch resolves this cycle.
- resolvePC  in  32  PC of the resolving branch.
- resolveTaken  in  1  actual outcome.
- resolveTarget  in  32  actual branch target (nextPC + (imm<<2)).
- resolveNextPC  in  32  PC+4 of the resolving branch.
- resolvePredTaken  in  1  prediction carried down the pipe with the branch.
- resolvePredTarget  in  32  predicted target carried down the pipe.
- mispredict  out  1  flush request.
- redirectPC  out  32  correct next PC on mispredict.
- branchCount  out  32  resolved branches since reset.
- mispredictCount  out  32  mispredicts since reset.

Behaviour:
- Single clock domain. Reset is synchronous and active-low (resetN sampled on the rising clock edge; no asynchronous term).
- Address split:
  - index = PC[IDX_BITS+1:2]
  - tag = PC[31:IDX_BITS+2]
  - PC[1:0] ignored.
- Entry fields: valid, tag, cnt[1:0], target[31:0].
- Lookup is combinational, same cycle:
  - hit = valid & tag match.
  - predTaken = hit & cnt[1].
  - predTarget = predTaken ? target : fetchPC+4 (32-bit wrap).
- Update happens on the clock edge when resolveValid=1 and resetN=1:
  - Hit & taken: cnt = min(cnt+1, 3); target = resolveTarget.
  - Hit & not taken: cnt = max(cnt-1, 0); target unchanged; entry stays valid.
  - Miss & taken: allocate; valid=1, tag=resolvePC tag, cnt=CNT_INIT, target=resolveTarget. This overwrites any aliasing entry.
  - Miss & not taken: no table change.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass). The new state is visible the next cycle.
- Mispredict detection is combinational:
  - mispredict = resolveValid & ((resolveTaken != resolvePredTaken) | (resolveTaken & resolveTarget != resolvePredTarget)).
  - redirectPC = resolveTaken ? resolveTarget : resolveNextPC when resolveValid=1; 0 otherwise.
- Statistics:
  - branchCount increments on every resolveValid.
  - mispredictCount increments when mispredict=1.
  - Both saturate at 32'hFFFF_FFFF (no wrap).
- Reset (resetN=0 at edge):
  - All valid bits, cnt fields and targets cleared to 0; both counters 0.
  - Reset wins over a simultaneous resolveValid; that update and its count are dropped.
  - Mid-operation reset requires no drain.
- Reset values of outputs (table empty after reset):
  - predTaken=0, predTarget=fetchPC+4.
  - mispredict=0 and redirectPC=0 (with resolveValid=0).
  - branchCount=0, mispredictCount=0.
- Only conditional branches (REGIMM, BEQ, BNE, BLEZ, BGTZ) are sent; jumps are never presented on the resolve port.

Decomposition:
- Shared package/include: WORD width macro, IDX/TAG width derivations, CNT_INIT encodings (SNT=0, WNT=1, WT=2, ST=3).
- One natural sub-module: sat_counter2 (2-bit saturating up/down counter, combinational next-state). Used per update; the BTB arrays stay in the top module.

Test Plan:
- Reset, then fetchPC=0x0040_0010 → predTaken=0, predTarget=0x0040_0014; counters 0.
- Resolve PC=0x0040_0010, taken, target=0x0040_0100, predTaken=0 → mispredict=1, redirectPC=0x0040_0100. Next cycle fetch of the same PC → predTaken=1, predTarget=0x0040_0100; branchCount=1, mispredictCount=1.
- Same branch resolved not-taken twice (cnt 2→1→0) → predTaken=0 after the first update. Then 3 takens → cnt saturates at 3; one not-taken still predicts taken.
- Alias check: PC 0x0040_0010 and 0x0040_0050 share index 4. A taken resolve of 0x0040_0050 evicts the entry. Fetch of 0x0040_0010 → predTaken=0; same-cycle lookup during the update returns the old entry.
- Resolve taken with matching predTaken=1 but resolvePredTarget=0x0040_0200 vs actual 0x0040_0100 → mispredict=1, redirectPC=0x0040_0100. Not-taken correct prediction → mispredict=0.
- Assert resetN=0 in the same cycle as resolveValid=1 → table empty, branchCount=0 next cycle.
